// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared definitions for the Gray-code sequence monitor:
//               FSM state encoding and default widths.
//               Contents:
//                 state_t             - HUNT / LOCKED tracking states
//                 C_WIDTH_DEFAULT     - default Gray code width (bits)
//                 C_CNT_W_DEFAULT     - default wrap counter width (bits)
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int C_WIDTH_DEFAULT = 3;
  localparam int C_CNT_W_DEFAULT = 4;

  // HUNT: no reference sample yet, the next valid code is accepted as-is.
  // LOCKED: the previous decode is known and each new sample is checked.
  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_monitor_if
// Description : Bus between an upstream Gray counter / consumer and the
//               Gray sequence monitor.
//               Signals:
//                 Valid      - Gray_In is sampled this cycle
//                 Gray_In    - Gray-coded count (WIDTH bits)
//                 Binary     - decoded value of the last accepted sample
//                 Out_Valid  - one-cycle pulse, new Binary value
//                 Locked     - monitor is tracking a valid sequence
//                 Seq_Error  - one-cycle pulse on a sequence violation
//                 Wrap       - one-cycle pulse on a max -> 0 step
//                 Overflow   - sticky, set on the first wrap
//                 Wrap_Count - saturating number of wraps (CNT_W bits)
//               Modports: master (stimulus side), slave (monitor side).
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_monitor_if
  import gray_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT,
  parameter int CNT_W = C_CNT_W_DEFAULT
) ();

  logic             Valid;
  logic [WIDTH-1:0] Gray_In;
  logic [WIDTH-1:0] Binary;
  logic             Out_Valid;
  logic             Locked;
  logic             Seq_Error;
  logic             Wrap;
  logic             Overflow;
  logic [CNT_W-1:0] Wrap_Count;

  modport master (
    output Valid,
    output Gray_In,
    input  Binary,
    input  Out_Valid,
    input  Locked,
    input  Seq_Error,
    input  Wrap,
    input  Overflow,
    input  Wrap_Count
  );

  modport slave (
    input  Valid,
    input  Gray_In,
    output Binary,
    output Out_Valid,
    output Locked,
    output Seq_Error,
    output Wrap,
    output Overflow,
    output Wrap_Count
  );

endinterface : gray_monitor_if
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin
// Description : Purely combinational Gray-to-binary decoder.
//               Ports:
//                 i_gray - Gray-coded input (WIDTH bits)
//                 o_bin  - binary decode (WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT
) (
  input  wire logic [WIDTH-1:0] i_gray,
  output logic      [WIDTH-1:0] o_bin
);

  // b[i] = b[i+1] ^ g[i] unrolls to the XOR of all Gray bits from the MSB
  // down to bit i; writing it that way keeps each bit an independent
  // reduction instead of a ripple chain through o_bin.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
  end

endmodule : gray2bin
`default_nettype wire

// File: rtl/gray_monitor.sv
`default_nettype none
// ============================================================================
// Module      : gray_monitor
// Description : Decodes a Gray-coded count and checks that successive
//               samples either hold or advance by exactly one (mod 2^WIDTH).
//               Flags sequence violations, wraps, a sticky overflow and a
//               saturating wrap count. All outputs are registered.
//               Ports:
//                 Clk     - clock, rising edge
//                 Reset_n - synchronous active-low reset
//                 bus     - gray_monitor_if.slave (Valid/Gray_In in,
//                           Binary/Out_Valid/Locked/Seq_Error/Wrap/
//                           Overflow/Wrap_Count out)
// Revision    : 1.0 - initial release
// ============================================================================
module gray_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH = C_WIDTH_DEFAULT,
  parameter int CNT_W = C_CNT_W_DEFAULT
) (
  input  wire logic     Clk,
  input  wire logic     Reset_n,
  gray_monitor_if.slave bus
);

  localparam logic [WIDTH-1:0] C_CODE_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

  // --------------------------------------------------------------------------
  // State and output registers. Initialisers give the reset values from
  // power-up so simulation starts clean before the first reset edge.
  // --------------------------------------------------------------------------
  state_t           r_state      = HUNT;
  logic [WIDTH-1:0] r_prev       = '0;
  logic [WIDTH-1:0] r_binary     = '0;
  logic             r_out_valid  = 1'b0;
  logic             r_seq_error  = 1'b0;
  logic             r_wrap       = 1'b0;
  logic             r_overflow   = 1'b0;
  logic [CNT_W-1:0] r_wrap_count = '0;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_prev_nxt;
  logic [WIDTH-1:0] w_binary_nxt;
  logic             w_out_valid_nxt;
  logic             w_seq_error_nxt;
  logic             w_wrap_nxt;
  logic             w_overflow_nxt;
  logic [CNT_W-1:0] w_wrap_count_nxt;

  // Decode and sequence checks
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_prev_plus1;
  logic             w_hold;
  logic             w_step;
  logic             w_is_wrap;

  gray2bin #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .i_gray (bus.Gray_In),
    .o_bin  (w_bin)
  );

  // Natural WIDTH-bit overflow gives the mod 2^WIDTH increment.
  assign w_prev_plus1 = r_prev + 1'b1;
  assign w_hold       = (w_bin == r_prev);
  assign w_step       = (w_bin == w_prev_plus1);
  // A legal step out of the max code can only land on zero.
  assign w_is_wrap    = w_step && (r_prev == C_CODE_MAX);

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_binary_nxt     = r_binary;
    w_out_valid_nxt  = 1'b0;
    w_seq_error_nxt  = 1'b0;
    w_wrap_nxt       = 1'b0;
    w_overflow_nxt   = r_overflow;
    w_wrap_count_nxt = r_wrap_count;

    if (bus.Valid) begin
      // Every accepted sample is published, legal or not.
      w_binary_nxt    = w_bin;
      w_out_valid_nxt = 1'b1;

      case (r_state)
        HUNT: begin
          // No reference yet: take this code as the starting point. A
          // max -> 0 transition seen from here is not counted as a wrap.
          w_prev_nxt  = w_bin;
          w_state_nxt = LOCKED;
        end

        LOCKED: begin
          if (w_hold) begin
            // Upstream counter paused; nothing to update.
            w_state_nxt = LOCKED;
          end else if (w_step) begin
            w_prev_nxt = w_bin;
            if (w_is_wrap) begin
              w_wrap_nxt     = 1'b1;
              w_overflow_nxt = 1'b1;
              if (r_wrap_count != C_CNT_MAX) begin
                w_wrap_count_nxt = r_wrap_count + 1'b1;
              end
            end
          end else begin
            // Violation: drop the reference; the next sample re-locks.
            w_seq_error_nxt = 1'b1;
            w_state_nxt     = HUNT;
          end
        end

        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register. Reset wins over a coincident Valid sample.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state      <= HUNT;
      r_prev       <= '0;
      r_binary     <= '0;
      r_out_valid  <= 1'b0;
      r_seq_error  <= 1'b0;
      r_wrap       <= 1'b0;
      r_overflow   <= 1'b0;
      r_wrap_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_binary     <= w_binary_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_seq_error  <= w_seq_error_nxt;
      r_wrap       <= w_wrap_nxt;
      r_overflow   <= w_overflow_nxt;
      r_wrap_count <= w_wrap_count_nxt;
    end
  end

  assign bus.Binary     = r_binary;
  assign bus.Out_Valid  = r_out_valid;
  assign bus.Locked     = (r_state == LOCKED);
  assign bus.Seq_Error  = r_seq_error;
  assign bus.Wrap       = r_wrap;
  assign bus.Overflow   = r_overflow;
  assign bus.Wrap_Count = r_wrap_count;

endmodule : gray_monitor
`default_nettype wire

// File: tb/tb_gray_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_monitor
// Description : Directed self-checking bench for gray_monitor (WIDTH=3,
//               CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_monitor;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Gray code for binary index 0..7
  logic [2:0] g_tab [0:7];

  gray_monitor_if #(.WIDTH(3), .CNT_W(4)) bus ();

  gray_monitor #(
    .WIDTH (3),
    .CNT_W (4)
  ) u_dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic step(input logic v, input logic [2:0] g);
    bus.Valid   = v;
    bus.Gray_In = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    step(1'b0, 3'b000);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus.Binary !== 3'd0) $display("FAIL reset Binary got %0d want 0", bus.Binary); else pass_cnt++;
    total_cnt++; if (bus.Out_Valid !== 1'b0) $display("FAIL reset Out_Valid got %b want 0", bus.Out_Valid); else pass_cnt++;
    total_cnt++; if (bus.Locked !== 1'b0) $display("FAIL reset Locked got %b want 0", bus.Locked); else pass_cnt++;
    total_cnt++; if (bus.Seq_Error !== 1'b0) $display("FAIL reset Seq_Error got %b want 0", bus.Seq_Error); else pass_cnt++;
    total_cnt++; if (bus.Wrap !== 1'b0) $display("FAIL reset Wrap got %b want 0", bus.Wrap); else pass_cnt++;
    total_cnt++; if (bus.Overflow !== 1'b0) $display("FAIL reset Overflow got %b want 0", bus.Overflow); else pass_cnt++;
    total_cnt++; if (bus.Wrap_Count !== 4'd0) $display("FAIL reset Wrap_Count got %0d want 0", bus.Wrap_Count); else pass_cnt++;
  endtask

  // 000,001,011,010,110,111,101,100,000 -> 0..7,0 with one wrap at the end
  task automatic test_sequence();
    logic [2:0] exp_bin;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_bin = 3'(i % 8);
      step(1'b1, g_tab[i % 8]);
      total_cnt++; if (bus.Binary !== exp_bin) $display("FAIL seq[%0d] Binary got %0d want %0d", i, bus.Binary, exp_bin); else pass_cnt++;
      total_cnt++; if (bus.Out_Valid !== 1'b1) $display("FAIL seq[%0d] Out_Valid got %b want 1", i, bus.Out_Valid); else pass_cnt++;
      total_cnt++; if (bus.Locked !== 1'b1) $display("FAIL seq[%0d] Locked got %b want 1", i, bus.Locked); else pass_cnt++;
      total_cnt++; if (bus.Seq_Error !== 1'b0) $display("FAIL seq[%0d] Seq_Error got %b want 0", i, bus.Seq_Error); else pass_cnt++;
      total_cnt++; if (bus.Wrap !== (i == 8)) $display("FAIL seq[%0d] Wrap got %b want %b", i, bus.Wrap, (i == 8)); else pass_cnt++;
      total_cnt++; if (bus.Overflow !== (i == 8)) $display("FAIL seq[%0d] Overflow got %b want %b", i, bus.Overflow, (i == 8)); else pass_cnt++;
    end
    total_cnt++; if (bus.Wrap_Count !== 4'd1) $display("FAIL seq Wrap_Count got %0d want 1", bus.Wrap_Count); else pass_cnt++;
    step(1'b0, 3'b000);
    total_cnt++; if (bus.Wrap !== 1'b0) $display("FAIL seq Wrap pulse width got %b want 0", bus.Wrap); else pass_cnt++;
    total_cnt++; if (bus.Overflow !== 1'b1) $display("FAIL seq Overflow sticky got %b want 1", bus.Overflow); else pass_cnt++;
  endtask

  // 000,001 then 010 (decode 3, expected 2) -> error, unlock; 110 re-locks
  task automatic test_seq_error();
    do_reset();
    step(1'b1, 3'b000);
    step(1'b1, 3'b001);
    step(1'b1, 3'b010);
    total_cnt++; if (bus.Seq_Error !== 1'b1) $display("FAIL err Seq_Error got %b want 1", bus.Seq_Error); else pass_cnt++;
    total_cnt++; if (bus.Locked !== 1'b0) $display("FAIL err Locked got %b want 0", bus.Locked); else pass_cnt++;
    total_cnt++; if (bus.Binary !== 3'd3) $display("FAIL err Binary got %0d want 3", bus.Binary); else pass_cnt++;
    total_cnt++; if (bus.Out_Valid !== 1'b1) $display("FAIL err Out_Valid got %b want 1", bus.Out_Valid); else pass_cnt++;
    step(1'b1, 3'b110);
    total_cnt++; if (bus.Seq_Error !== 1'b0) $display("FAIL relock Seq_Error got %b want 0", bus.Seq_Error); else pass_cnt++;
    total_cnt++; if (bus.Locked !== 1'b1) $display("FAIL relock Locked got %b want 1", bus.Locked); else pass_cnt++;
    total_cnt++; if (bus.Binary !== 3'd4) $display("FAIL relock Binary got %0d want 4", bus.Binary); else pass_cnt++;
    // 4 -> 5 must be a legal step from the re-locked reference
    step(1'b1, 3'b111);
    total_cnt++; if (bus.Seq_Error !== 1'b0) $display("FAIL relock step Seq_Error got %b want 0", bus.Seq_Error); else pass_cnt++;
    total_cnt++; if (bus.Binary !== 3'd5) $display("FAIL relock step Binary got %0d want 5", bus.Binary); else pass_cnt++;
  endtask

  // Locked at 011, hold three times, then 5 idle cycles
  task automatic test_hold();
    do_reset();
    step(1'b1, 3'b000);
    step(1'b1, 3'b001);
    step(1'b1, 3'b011);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b011);
      total_cnt++; if (bus.Out_Valid !== 1'b1) $display("FAIL hold[%0d] Out_Valid got %b want 1", i, bus.Out_Valid); else pass_cnt++;
      total_cnt++; if (bus.Binary !== 3'd2) $display("FAIL hold[%0d] Binary got %0d want 2", i, bus.Binary); else pass_cnt++;
      total_cnt++; if (bus.Seq_Error !== 1'b0) $display("FAIL hold[%0d] Seq_Error got %b want 0", i, bus.Seq_Error); else pass_cnt++;
      total_cnt++; if (bus.Locked !== 1'b1) $display("FAIL hold[%0d] Locked got %b want 1", i, bus.Locked); else pass_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b110);
      total_cnt++; if (bus.Out_Valid !== 1'b0) $display("FAIL idle[%0d] Out_Valid got %b want 0", i, bus.Out_Valid); else pass_cnt++;
      total_cnt++; if (bus.Binary !== 3'd2) $display("FAIL idle[%0d] Binary got %0d want 2", i, bus.Binary); else pass_cnt++;
      total_cnt++; if (bus.Seq_Error !== 1'b0) $display("FAIL idle[%0d] Seq_Error got %b want 0", i, bus.Seq_Error); else pass_cnt++;
      total_cnt++; if (bus.Locked !== 1'b1) $display("FAIL idle[%0d] Locked got %b want 1", i, bus.Locked); else pass_cnt++;
    end
    step(1'b1, 3'b010);
    total_cnt++; if (bus.Binary !== 3'd3) $display("FAIL hold resume Binary got %0d want 3", bus.Binary); else pass_cnt++;
    total_cnt++; if (bus.Seq_Error !== 1'b0) $display("FAIL hold resume Seq_Error got %b want 0", bus.Seq_Error); else pass_cnt++;
  endtask

  // 17 full wraps: count saturates at 15, Overflow stays set
  task automatic test_saturation();
    logic [3:0] exp_cnt;
    do_reset();
    step(1'b1, 3'b000);
    total_cnt++; if (bus.Wrap !== 1'b0) $display("FAIL sat start Wrap got %b want 0", bus.Wrap); else pass_cnt++;
    for (int w = 1; w <= 17; w++) begin
      exp_cnt = (w > 15) ? 4'd15 : 4'(w);
      for (int k = 1; k <= 8; k++) begin
        step(1'b1, g_tab[k % 8]);
        if (k == 4) begin
          total_cnt++; if (bus.Wrap !== 1'b0) $display("FAIL sat[%0d] mid Wrap got %b want 0", w, bus.Wrap); else pass_cnt++;
        end
      end
      total_cnt++; if (bus.Wrap !== 1'b1) $display("FAIL sat[%0d] Wrap got %b want 1", w, bus.Wrap); else pass_cnt++;
      total_cnt++; if (bus.Wrap_Count !== exp_cnt) $display("FAIL sat[%0d] Wrap_Count got %0d want %0d", w, bus.Wrap_Count, exp_cnt); else pass_cnt++;
      total_cnt++; if (bus.Overflow !== 1'b1) $display("FAIL sat[%0d] Overflow got %b want 1", w, bus.Overflow); else pass_cnt++;
    end
  endtask

  // Reset coincident with Valid=1/111 after two wraps
  task automatic test_reset_priority();
    do_reset();
    step(1'b1, 3'b000);
    for (int w = 0; w < 2; w++)
      for (int k = 1; k <= 8; k++)
        step(1'b1, g_tab[k % 8]);
    total_cnt++; if (bus.Wrap_Count !== 4'd2) $display("FAIL rstpri pre Wrap_Count got %0d want 2", bus.Wrap_Count); else pass_cnt++;
    Reset_n = 1'b0;
    step(1'b1, 3'b111);
    Reset_n = 1'b1;
    total_cnt++; if (bus.Binary !== 3'd0) $display("FAIL rstpri Binary got %0d want 0", bus.Binary); else pass_cnt++;
    total_cnt++; if (bus.Out_Valid !== 1'b0) $display("FAIL rstpri Out_Valid got %b want 0", bus.Out_Valid); else pass_cnt++;
    total_cnt++; if (bus.Locked !== 1'b0) $display("FAIL rstpri Locked got %b want 0", bus.Locked); else pass_cnt++;
    total_cnt++; if (bus.Overflow !== 1'b0) $display("FAIL rstpri Overflow got %b want 0", bus.Overflow); else pass_cnt++;
    total_cnt++; if (bus.Wrap_Count !== 4'd0) $display("FAIL rstpri Wrap_Count got %0d want 0", bus.Wrap_Count); else pass_cnt++;
    total_cnt++; if (bus.Wrap !== 1'b0) $display("FAIL rstpri Wrap got %b want 0", bus.Wrap); else pass_cnt++;
    step(1'b1, 3'b101);
    total_cnt++; if (bus.Locked !== 1'b1) $display("FAIL rstpri next Locked got %b want 1", bus.Locked); else pass_cnt++;
    total_cnt++; if (bus.Seq_Error !== 1'b0) $display("FAIL rstpri next Seq_Error got %b want 0", bus.Seq_Error); else pass_cnt++;
    total_cnt++; if (bus.Binary !== 3'd6) $display("FAIL rstpri next Binary got %0d want 6", bus.Binary); else pass_cnt++;
  endtask

  // 000 as first sample is not a wrap; neither is 7 -> 0 accepted in HUNT
  task automatic test_first_zero();
    do_reset();
    step(1'b1, 3'b000);
    total_cnt++; if (bus.Wrap !== 1'b0) $display("FAIL first0 Wrap got %b want 0", bus.Wrap); else pass_cnt++;
    total_cnt++; if (bus.Wrap_Count !== 4'd0) $display("FAIL first0 Wrap_Count got %0d want 0", bus.Wrap_Count); else pass_cnt++;
    total_cnt++; if (bus.Locked !== 1'b1) $display("FAIL first0 Locked got %b want 1", bus.Locked); else pass_cnt++;
    step(1'b1, 3'b001);
    step(1'b1, 3'b100);
    total_cnt++; if (bus.Seq_Error !== 1'b1) $display("FAIL hunt7 Seq_Error got %b want 1", bus.Seq_Error); else pass_cnt++;
    step(1'b1, 3'b000);
    total_cnt++; if (bus.Wrap !== 1'b0) $display("FAIL hunt7to0 Wrap got %b want 0", bus.Wrap); else pass_cnt++;
    total_cnt++; if (bus.Overflow !== 1'b0) $display("FAIL hunt7to0 Overflow got %b want 0", bus.Overflow); else pass_cnt++;
    total_cnt++; if (bus.Wrap_Count !== 4'd0) $display("FAIL hunt7to0 Wrap_Count got %0d want 0", bus.Wrap_Count); else pass_cnt++;
    total_cnt++; if (bus.Locked !== 1'b1) $display("FAIL hunt7to0 Locked got %b want 1", bus.Locked); else pass_cnt++;
  endtask

  initial begin
    g_tab[0] = 3'b000; g_tab[1] = 3'b001; g_tab[2] = 3'b011; g_tab[3] = 3'b010;
    g_tab[4] = 3'b110; g_tab[5] = 3'b111; g_tab[6] = 3'b101; g_tab[7] = 3'b100;
    bus.Valid   = 1'b0;
    bus.Gray_In = 3'b000;
    @(posedge Clk);
    #1;
    test_reset();
    test_sequence();
    test_seq_error();
    test_hold();
    test_saturation();
    test_reset_priority();
    test_first_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_gray_monitor
`default_nettype wire

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 3, giving the Gray code width in bits (legal range 2..8).
REQ-002 The module SHALL have parameter CNT_W, default 4, giving the wrap counter width in bits.
REQ-003 Port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port Valid, input, 1 bit: Gray_In is sampled this cycle.
REQ-006 Port Gray_In, input, WIDTH bits: Gray-coded count from the upstream Gray counter.
REQ-007 Port Binary, output, WIDTH bits, registered: binary decode of the last accepted sample.
REQ-008 Port Out_Valid, output, 1 bit, registered: one-cycle pulse marking a new Binary value.
REQ-009 Port Locked, output, 1 bit, registered: the monitor is tracking a valid sequence.
REQ-010 Port Seq_Error, output, 1 bit, registered: one-cycle pulse on a sequence violation.
REQ-011 Port Wrap, output, 1 bit, registered: one-cycle pulse when the sequence wraps from max to 0.
REQ-012 Port Overflow, output, 1 bit, registered: sticky flag set on the first wrap.
REQ-013 Port Wrap_Count, output, CNT_W bits, registered: number of wraps, saturating.

Function
REQ-014 Decode rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i below WIDTH-1.
REQ-015 Latency: a sample accepted in cycle N SHALL appear on Binary, with Out_Valid=1, in cycle N+1.
REQ-016 Cycles with Valid=0: no state change; Out_Valid, Seq_Error and Wrap are 0; Binary holds its value.
REQ-017 FSM states: HUNT and LOCKED.
REQ-018 HUNT with Valid=1: accept any code, store its decode as prev, go to LOCKED, no error.
REQ-019 LOCKED with Valid=1 and decode == prev: hold is legal; Out_Valid pulses; no error.
REQ-020 LOCKED with Valid=1 and decode == prev+1 mod 2^WIDTH: legal step; update prev.
REQ-021 LOCKED with Valid=1 and any other decode: Seq_Error pulses; go to HUNT; Binary still shows the new decode; prev is not used further.
REQ-022 A sample that fails the check also does not lock; the next valid sample re-locks per REQ-018.
REQ-023 Wrap condition: a legal step with prev == 2^WIDTH-1 and decode == 0.
REQ-024 On a wrap: Wrap pulses; Overflow is set to 1 and stays set; Wrap_Count increments and saturates at 2^CNT_W-1.
REQ-025 A step from max to 0 accepted in HUNT is not a wrap.
REQ-026 Locked SHALL equal 1 exactly when the FSM is in LOCKED.
REQ-027 Arithmetic: prev+1 SHALL be computed modulo 2^WIDTH; the Wrap_Count increment SHALL NOT roll over.

Reset
REQ-028 When Reset_n=0 at a rising edge: FSM goes to HUNT; Binary=0; Out_Valid=0; Locked=0; Seq_Error=0; Wrap=0; Overflow=0; Wrap_Count=0.
REQ-029 Reset SHALL take priority over Valid in the same cycle; the sample is discarded.
REQ-030 Reset mid-sequence SHALL clear Overflow and Wrap_Count; the next valid sample is handled as in HUNT.
REQ-031 Registers SHALL also hold the reset values from power-up for simulation.

Structure
REQ-032 Package gray_pkg SHALL hold the FSM state encoding (HUNT, LOCKED) and the default WIDTH/CNT_W constants.
REQ-033 The combinational decode SHALL be a sub-module, gray2bin (WIDTH-parameterised, no state), instantiated once.
REQ-034 The FSM, prev register, flags and counter SHALL live in gray_monitor.

Verification
REQ-035 Reset then Valid=1 with 000,001,011,010,110,111,101,100,000 -> Binary 0..7,0; Locked=1 from the first sample; Wrap pulses once at the final 000; Overflow=1; Wrap_Count=1.
REQ-036 Locked, then 000,001,010 -> decode 3 is not prev+1 -> Seq_Error pulse, Locked=0; then 110 -> re-locks, no error.
REQ-037 Locked at 011, hold Valid=1 with 011 three times, then Valid=0 for 5 cycles -> no errors; Out_Valid pulses only on the three Valid cycles; Binary=2 throughout.
REQ-038 Run 17 full wraps with CNT_W=4 -> Wrap_Count stays at 15 after the 15th wrap; Overflow stays 1.
REQ-039 Assert Reset_n=0 after 2 wraps, in the same cycle as Valid=1 with 111 -> all outputs 0; sample ignored; next sample 101 -> Locked=1, no error.
REQ-040 First sample after reset is 000 while prev is undefined (HUNT), preceded by no step -> no Wrap; Wrap_Count=0.
